// File: rtl/sample_capture_ctrl.sv
// Capture sequencer for the folded FIR output stream.
// On arm it discards skip_len leading samples and then writes cap_len samples
// to the 1024x20 sample buffer, starting at address 0.
// The same registered RAM port is shared with a host readout path.
// A capture write always wins the port. A host read uses it only in a cycle
// when no write is due.
//
// Host read handshake: the host raises rd_req with a stable rd_addr and holds
// both until rd_ack. rd_ack is a one-cycle pulse, and rd_data is valid in that
// cycle. Only one read is in flight at a time. The host drops rd_req in the
// cycle after rd_ack; if rd_req is still high then, a new read is issued.
module sample_capture_ctrl #(
   parameter int DW  = 20,
   parameter int AW  = 10,
   parameter int SKW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            arm,
   input  logic            abort,
   input  logic [AW:0]     cap_len,
   input  logic [SKW-1:0]  skip_len,
   input  logic            din_valid,
   input  logic [DW-1:0]   din,
   input  logic            rd_req,
   input  logic [AW-1:0]   rd_addr,
   output logic            rd_ack,
   output logic [DW-1:0]   rd_data,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata,
   output logic            busy,
   output logic            done,
   output logic [AW:0]     wr_count
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SKIP    = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   // Full buffer length; used when cap_len is 0 or larger than the buffer.
   localparam logic [AW:0] FULL_LEN = {1'b1, {AW{1'b0}}};

   state_t          state_q, state_d;
   logic [AW:0]     len_q, len_d;
   logic [SKW-1:0]  skip_cnt_q, skip_cnt_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [AW:0]     wr_count_q, wr_count_d;
   logic            mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic            rd_p1_q, rd_p1_d;   // read address is on the RAM port
   logic            rd_p2_q, rd_p2_d;   // RAM data is valid on mem_rdata
   logic            rd_ack_q, rd_ack_d;
   logic [DW-1:0]   rd_data_q, rd_data_d;

   logic            write_due;
   logic            rd_inflight;
   logic            rd_issue;

   // An abort drops the sample in that cycle. A read may only take a cycle with no write due.
   assign write_due   = (state_q == S_CAPTURE) && din_valid && !abort;
   assign rd_inflight = rd_p1_q | rd_p2_q | rd_ack_q;
   assign rd_issue    = rd_req && !rd_inflight && !write_due;

   // Next state and capture counters; abort overrides everything, including arm
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      skip_cnt_d = skip_cnt_q;
      wr_addr_d  = wr_addr_q;
      wr_count_d = wr_count_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  len_d      = ((cap_len == '0) || (cap_len > FULL_LEN)) ? FULL_LEN : cap_len;
                  skip_cnt_d = skip_len;
                  wr_addr_d  = '0;
                  wr_count_d = '0;
                  state_d    = (skip_len != '0) ? S_SKIP : S_CAPTURE;
               end
            end
            S_SKIP: begin
               if (din_valid) begin
                  skip_cnt_d = skip_cnt_q - 1'b1;
                  if (skip_cnt_q == SKW'(1)) state_d = S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (write_due) begin
                  wr_addr_d  = wr_addr_q + 1'b1;
                  wr_count_d = wr_count_q + 1'b1;
                  if (wr_count_d == len_q) state_d = S_DONE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // RAM port arbitration (write first) and the three-stage read return pipeline
   always_comb begin
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (write_due) begin
         mem_we_d    = 1'b1;
         mem_addr_d  = wr_addr_q;
         mem_wdata_d = din;
      end else if (rd_issue) begin
         mem_addr_d = rd_addr;
      end
      rd_p1_d   = rd_issue;
      rd_p2_d   = rd_p1_q;
      rd_ack_d  = rd_p2_q;
      rd_data_d = rd_p2_q ? mem_rdata : rd_data_q;
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         skip_cnt_q  <= '0;
         wr_addr_q   <= '0;
         wr_count_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_p1_q     <= 1'b0;
         rd_p2_q     <= 1'b0;
         rd_ack_q    <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         skip_cnt_q  <= skip_cnt_d;
         wr_addr_q   <= wr_addr_d;
         wr_count_q  <= wr_count_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd_p1_q     <= rd_p1_d;
         rd_p2_q     <= rd_p2_d;
         rd_ack_q    <= rd_ack_d;
         rd_data_q   <= rd_data_d;
      end
   end

   assign rd_ack    = rd_ack_q;
   assign rd_data   = rd_data_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q == S_SKIP) || (state_q == S_CAPTURE);
   assign done      = (state_q == S_DONE);
   assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_sample_capture_ctrl.sv
// Bench for sample_capture_ctrl: a transaction-level model of the capture and
// readout rules, a RAM with one-cycle read latency, and directed scenarios.
module tb_sample_capture_ctrl;

   localparam int DW  = 20;
   localparam int AW  = 10;
   localparam int SKW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            arm, abort;
   logic [AW:0]     cap_len;
   logic [SKW-1:0]  skip_len;
   logic            din_valid;
   logic [DW-1:0]   din;
   logic            rd_req;
   logic [AW-1:0]   rd_addr;
   logic            rd_ack;
   logic [DW-1:0]   rd_data;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;
   logic            busy, done;
   logic [AW:0]     wr_count;

   sample_capture_ctrl #(.DW(DW), .AW(AW), .SKW(SKW)) dut (
      .clk(clk), .rst(rst), .arm(arm), .abort(abort),
      .cap_len(cap_len), .skip_len(skip_len),
      .din_valid(din_valid), .din(din),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .done(done), .wr_count(wr_count)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- sample buffer RAM ----------------
   logic [DW-1:0] ram [1024];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   // ---------------- counters ----------------
   int n_checks = 0;
   int n_errors = 0;
   int wr_seen  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Model of one capture session: it is either active or finished. It tracks
   // how many samples still need to be skipped and how many have been stored.
   // Each stored sample becomes an expected write in the cycle after it arrives.
   logic [AW+DW-1:0] exp_q[$];
   logic [DW-1:0]    exp_mem [1024];
   bit   m_act, m_done, have_read, wrote;
   int   m_len, m_skip, m_stored;
   int   cyc;
   int   rd_issue_cyc, rd_ack_cyc;
   logic [AW-1:0] rd_addr_m;

   initial cyc = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_act = 0; m_done = 0; m_len = 0; m_skip = 0; m_stored = 0;
         have_read = 0;
         exp_q.delete();
      end else begin
         wrote = 0;
         if (abort) begin
            m_act = 0; m_done = 0;
         end else if (arm && !m_act) begin
            m_len    = (cap_len == 0 || cap_len > 1024) ? 1024 : int'(cap_len);
            m_skip   = int'(skip_len);
            m_stored = 0;
            m_act    = 1;
            m_done   = 0;
         end else if (m_act && din_valid) begin
            if (m_skip > 0) begin
               m_skip--;
            end else begin
               exp_q.push_back({AW'(m_stored), din});
               exp_mem[m_stored] = din;
               m_stored++;
               wrote = 1;
               if (m_stored == m_len) begin
                  m_act = 0; m_done = 1;
               end
            end
         end
         if (rd_req && !(have_read && cyc <= rd_ack_cyc) && !wrote) begin
            have_read    = 1;
            rd_addr_m    = rd_addr;
            rd_issue_cyc = cyc + 1;
            rd_ack_cyc   = cyc + 3;
         end
         cyc++;
      end
   end

   // ---------------- scoreboard compare, every cycle ----------------
   always @(negedge clk) begin
      logic [AW+DW-1:0] e;
      bit exp_we, exp_ack;
      chk("busy", busy, m_act);
      chk("done", done, m_done);
      chk("wr_count", wr_count, m_stored);
      exp_we = (exp_q.size() > 0);
      chk("mem_we", mem_we, exp_we);
      if (mem_we) wr_seen++;
      if (exp_we) begin
         e = exp_q.pop_front();
         chk("mem_addr_wr", mem_addr, e[AW+DW-1:DW]);
         chk("mem_wdata", mem_wdata, e[DW-1:0]);
      end
      if (have_read && cyc == rd_issue_cyc) begin
         chk("rd_issue_we", mem_we, 0);
         chk("rd_issue_addr", mem_addr, rd_addr_m);
      end
      exp_ack = have_read && (cyc == rd_ack_cyc);
      chk("rd_ack", rd_ack, exp_ack);
      if (exp_ack) chk("rd_data_model", rd_data, exp_mem[rd_addr_m]);
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         din_valid = 1'b0;
      end
   endtask

   task automatic send(input logic [DW-1:0] d);
      @(negedge clk);
      din_valid = 1'b1;
      din       = d;
   endtask

   task automatic arm_cap(input int len, input int skip);
      @(negedge clk);
      din_valid = 1'b0;
      cap_len   = (AW+1)'(len);
      skip_len  = SKW'(skip);
      arm       = 1'b1;
      @(negedge clk);
      arm = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
      bit got;
      @(negedge clk);
      din_valid = 1'b0;
      rd_req    = 1'b1;
      rd_addr   = a;
      lat = 0; d = '0; got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (rd_ack) begin
            got = 1;
            d   = rd_data;
         end
      end
      rd_req = 1'b0;
      chk("rd_ack_seen", got, 1);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // ---------------- directed scenarios ----------------
   initial begin
      logic [DW-1:0] d;
      int lat, ack_i, k;
      bit got;
      logic [DW-1:0] rdv;

      rst = 1'b1; arm = 1'b0; abort = 1'b0; cap_len = '0; skip_len = '0;
      din_valid = 1'b0; din = '0; rd_req = 1'b0; rd_addr = '0;
      for (int i = 0; i < 1024; i++) ram[i] = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wr_count", wr_count, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rd_ack", rd_ack, 0);
      chk("rst_rd_data", rd_data, 0);
      rst = 1'b0;

      // Asynchronous reset after 5 writes, then a clean restart at address 0
      arm_cap(10, 0);
      for (int i = 0; i < 5; i++) send(DW'(20 + i));
      idle(1);
      chk("pre_rst_wr_count", wr_count, 5);
      #2 rst = 1'b1;
      #1;
      chk("async_busy", busy, 0);
      chk("async_wr_count", wr_count, 0);
      chk("async_mem_we", mem_we, 0);
      chk("async_mem_addr", mem_addr, 0);
      chk("async_mem_wdata", mem_wdata, 0);
      @(negedge clk);
      rst = 1'b0;
      arm_cap(3, 0);
      for (int i = 0; i < 3; i++) send(DW'(7 + i));
      idle(2);
      chk("restart_done", done, 1);
      chk("restart_wr_count", wr_count, 3);

      // Skip two settling samples, store four signed samples
      arm_cap(4, 2);
      for (int i = -3; i <= 5; i++) send(DW'(i));
      idle(2);
      chk("skip_done", done, 1);
      chk("skip_wr_count", wr_count, 4);

      // Host read in DONE: address 2 holds 1, ack three cycles after rd_req
      do_read(10'd2, d, lat);
      chk("rd2_data", d, DW'(1));
      chk("rd2_latency", lat, 3);
      idle(2);

      // Read collides with capture writes: writes go first, read gets the gap
      arm_cap(8, 0);
      k = 0; got = 0; ack_i = -1; rdv = '0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (rd_ack && !got) begin
            got = 1; rdv = rd_data; ack_i = i; rd_req = 1'b0;
         end
         din_valid = (k < 10) && (i % 4 != 3);
         din       = DW'(100 + k);
         if (din_valid) k++;
         if (i == 1) begin
            rd_req  = 1'b1;
            rd_addr = '0;
         end
      end
      rd_req = 1'b0;
      idle(2);
      chk("coll_got_ack", got, 1);
      chk("coll_rd_data", rdv, DW'(100));
      chk("coll_ack_cycle", ack_i, 6);
      chk("coll_wr_count", wr_count, 8);
      chk("coll_done", done, 1);

      // Abort in SKIP with arm in the same cycle: abort wins
      arm_cap(4, 5);
      send(DW'(50));
      send(DW'(51));
      @(negedge clk);
      abort = 1'b1; arm = 1'b1; din_valid = 1'b1; din = DW'(52);
      @(negedge clk);
      abort = 1'b0; arm = 1'b0; din_valid = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_wr_count", wr_count, 0);
      idle(2);
      arm_cap(2, 1);
      send(DW'(60)); send(DW'(61)); send(DW'(62));
      idle(2);
      chk("post_abort_done", done, 1);
      chk("post_abort_wr_count", wr_count, 2);
      do_read(10'd1, d, lat);
      chk("post_abort_rd1", d, DW'(62));
      idle(2);

      // Full buffer (cap_len=0), one sample every third cycle, no wrap
      arm_cap(0, 0);
      wr_seen = 0;
      for (int i = 0; i < 3078; i++) begin
         if (i % 3 == 0) send(DW'(i / 3));
         else idle(1);
      end
      idle(3);
      chk("full_done", done, 1);
      chk("full_wr_count", wr_count, 1024);
      chk("full_writes", wr_seen, 1024);
      do_read(10'd1023, d, lat);
      chk("full_rd1023", d, DW'(1023));
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
